// File: rtl/exp_in_filter.sv
// rtl/exp_in_filter.sv - expansion GPIO input synchronizer, debounce filter and edge-event register slave
// Channels are ordered {N[DWE-1:0], P[DWE-1:0]} everywhere, including the register bit layout.
module exp_in_filter #(
  parameter int DWE  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [DWE-1:0]  exp_p_in_i,
  input  logic [DWE-1:0]  exp_n_in_i,
  output logic [DWE-1:0]  exp_p_dat_o,
  output logic [DWE-1:0]  exp_n_dat_o,
  output logic            irq_o,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack
);

  localparam int NCH = 2 * DWE;

  logic [NCH-1:0]  sync1, sync2, filt;
  logic [NCH-1:0]  rise_en, fall_en, status;
  logic [NCH-1:0]  upd, set_bits, clr_bits;
  logic [CNTW-1:0] len;
  logic [CNTW-1:0] cnt [NCH];
  logic [19:0]     addr;
  logic [31:0]     rd_mux;
  logic            unused_bits;

  assign addr        = sys_addr[19:0];
  assign unused_bits = ^{sys_addr[31:20], sys_wdata[31:NCH]};

  // A channel flips once the synchronized level has disagreed long enough;
  // >= lets a count left above a freshly shrunk LEN resolve on the next cycle.
  always_comb begin
    upd = '0;
    for (int i = 0; i < NCH; i++) begin
      upd[i] = (sync2[i] != filt[i]) && (cnt[i] >= len);
    end
  end

  assign set_bits = upd & ((sync2 & rise_en) | (~sync2 & fall_en));
  assign clr_bits = (sys_wen && addr == 20'h0000C) ? sys_wdata[NCH-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      len     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      irq_o   <= 1'b0;
      sys_ack <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= {exp_n_in_i, exp_p_in_i};
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNTW'(1);
        end
      end
      // Set wins over a simultaneous clear of the same bit.
      status  <= (status & ~clr_bits) | set_bits;
      irq_o   <= |status;
      sys_ack <= sys_wen | sys_ren;
      if (sys_wen) begin
        case (addr)
          20'h00000: len     <= sys_wdata[CNTW-1:0];
          20'h00004: rise_en <= sys_wdata[NCH-1:0];
          20'h00008: fall_en <= sys_wdata[NCH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      20'h00000: rd_mux = {{(32-CNTW){1'b0}}, len};
      20'h00004: rd_mux = {{(32-NCH){1'b0}}, rise_en};
      20'h00008: rd_mux = {{(32-NCH){1'b0}}, fall_en};
      20'h0000C: rd_mux = {{(32-NCH){1'b0}}, status};
      20'h00010: rd_mux = {{(32-NCH){1'b0}}, sync2};
      20'h00014: rd_mux = {{(32-NCH){1'b0}}, filt};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sys_wen || sys_ren) begin
      sys_rdata <= rd_mux;
    end
  end

  assign sys_err     = 1'b0;
  assign exp_p_dat_o = filt[DWE-1:0];
  assign exp_n_dat_o = filt[NCH-1:DWE];

endmodule

// File: tb/tb_exp_in_filter.sv
// tb/tb_exp_in_filter.sv - bench for exp_in_filter: register vectors, directed corners, random vs reference model
module tb_exp_in_filter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] pins;
  logic [7:0]  p_dat, n_dat;
  logic        irq, err, ack;
  logic [31:0] addr, wdata, rdata;
  logic        wen, ren;

  int checks = 0;
  int errors = 0;

  exp_in_filter #(.DWE(8), .CNTW(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .exp_p_in_i(pins[7:0]), .exp_n_in_i(pins[15:8]),
    .exp_p_dat_o(p_dat), .exp_n_dat_o(n_dat), .irq_o(irq),
    .sys_addr(addr), .sys_wdata(wdata), .sys_wen(wen), .sys_ren(ren),
    .sys_rdata(rdata), .sys_err(err), .sys_ack(ack)
  );

  always #5 clk = ~clk;

  // Reference model: filtered level flips when the last LEN+1 synchronized samples all differ from it.
  logic [15:0] m_f, m_st, m_re, m_fe, m_len;
  logic        m_irq, m_ack;
  logic [31:0] m_rdata;
  logic [15:0] pq[$];
  logic [15:0] shist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[19:0])
      20'h00000: return {16'h0, m_len};
      20'h00004: return {16'h0, m_re};
      20'h00008: return {16'h0, m_fe};
      20'h0000C: return {16'h0, m_st};
      20'h00010: return {16'h0, pq[0]};
      20'h00014: return {16'h0, m_f};
      default:   return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [15:0] s_seen, newf, setb, clrb;
    int n;
    bit all_diff;
    if (!rstn) begin
      m_f = '0; m_st = '0; m_re = '0; m_fe = '0; m_len = '0;
      m_irq = 1'b0; m_ack = 1'b0;
      pq.delete(); pq.push_back(16'h0); pq.push_back(16'h0);
      shist.delete();
    end else begin
      if (wen || ren) m_rdata = m_read(addr);
      m_ack = wen | ren;
      m_irq = |m_st;
      s_seen = pq[0];
      pq.push_back(pins);
      void'(pq.pop_front());
      shist.push_back(s_seen);
      if (shist.size() > 300) void'(shist.pop_front());
      n = int'(m_len) + 1;
      newf = m_f;
      for (int i = 0; i < 16; i++) begin
        if (shist.size() >= n) begin
          all_diff = 1'b1;
          for (int j = 0; j < n; j++)
            if (shist[shist.size()-1-j][i] == m_f[i]) all_diff = 1'b0;
          if (all_diff) newf[i] = ~m_f[i];
        end
      end
      setb = (newf & ~m_f & m_re) | (~newf & m_f & m_fe);
      clrb = (wen && addr[19:0] == 20'h0000C) ? wdata[15:0] : 16'h0;
      m_st = (m_st & ~clrb) | setb;
      m_f  = newf;
      if (wen) begin
        case (addr[19:0])
          20'h00000: m_len = wdata[15:0];
          20'h00004: m_re  = wdata[15:0];
          20'h00008: m_fe  = wdata[15:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("p_dat", p_dat, m_f[7:0]);
    chk("n_dat", n_dat, m_f[15:8]);
    chk("irq", irq, m_irq);
    chk("ack", ack, m_ack);
    chk("err", err, 0);
    if (m_ack) chk("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd_expect(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    chk(nm, rdata, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int first, seen, op;
    rstn = 1'b0; pins = '0; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;

    vecs[0]  = '{32'h0000_0000, 32'hFFFF_1234, 32'h0000_1234};
    vecs[1]  = '{32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_BEEF};
    vecs[2]  = '{32'h0000_0008, 32'h1234_5678, 32'h0000_5678};
    vecs[3]  = '{32'hFFF0_0004, 32'h0000_00FF, 32'h0000_00FF};
    vecs[4]  = '{32'h0000_0010, 32'h0000_FFFF, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0014, 32'h0000_FFFF, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0018, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{32'h0000_000C, 32'h0000_FFFF, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0004, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0000};

    // Reset held with pins toggling
    for (int k = 0; k < 6; k++) begin
      pins = 16'($urandom);
      tick();
    end
    pins = '0;
    tick();
    rstn = 1'b1;
    rd_expect("rst_len", 32'h0, 32'h0);
    rd_expect("rst_status", 32'hC, 32'h0);
    rd_expect("rst_filt", 32'h14, 32'h0);

    for (int v = 0; v < 11; v++) begin
      wr(vecs[v].addr, vecs[v].wdata);
      rd_expect($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp);
    end

    // Bypass latency with LEN=0
    pins[0] = 1'b1;
    tick();
    tick();
    chk("bypass_not_yet", p_dat[0], 0);
    rd_expect("bypass_raw", 32'h10, 32'h1);
    chk("bypass_out", p_dat[0], 1);
    pins[0] = 1'b0;
    repeat (4) tick();

    // Debounce with LEN=4 on N2 (channel 10)
    wr(32'h0, 32'd4);
    wr(32'h4, 32'h0400);
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      pins[10] = (k < 4);
      tick();
      if (n_dat[2]) seen = 1;
    end
    chk("deb_short_filt", seen, 0);
    rd_expect("deb_short_status", 32'hC, 32'h0);
    first = 0;
    for (int k = 1; k <= 16; k++) begin
      pins[10] = (k <= 5);
      tick();
      if (n_dat[2] && first == 0) first = k;
    end
    chk("deb_latency", first, 7);
    rd_expect("deb_status", 32'hC, 32'h0400);
    wr(32'hC, 32'h0400);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      pins[10] = (k < 4) || (k >= 5 && k < 9);
      tick();
      if (n_dat[2]) seen = 1;
    end
    chk("deb_restart", seen, 0);

    // Events
    wr(32'h0, 32'h0);
    wr(32'h4, 32'h0001);
    wr(32'h8, 32'h0100);
    rd_expect("ev_clean", 32'hC, 32'h0);
    pins[0] = 1'b1; repeat (4) tick();
    pins[0] = 1'b0; repeat (4) tick();
    rd_expect("ev_p0", 32'hC, 32'h0001);
    chk("ev_irq", irq, 1);
    pins[8] = 1'b1; repeat (4) tick();
    pins[8] = 1'b0; repeat (4) tick();
    rd_expect("ev_n0", 32'hC, 32'h0101);
    wr(32'hC, 32'h0001);
    rd_expect("ev_w1c0", 32'hC, 32'h0100);
    wr(32'hC, 32'h0100);
    chk("ev_irq_hold", irq, 1);
    tick();
    chk("ev_irq_drop", irq, 0);

    // Collision: clear of bit 0 on the edge a rise qualifies
    pins[0] = 1'b1;
    tick();
    tick();
    wr(32'hC, 32'h0001);
    rd_expect("collision", 32'hC, 32'h0001);
    pins[0] = 1'b0;
    repeat (4) tick();
    wr(32'hC, 32'hFFFF);

    // LEN shrink mid-count
    wr(32'h0, 32'd100);
    pins[1] = 1'b1;
    repeat (50) tick();
    wr(32'h0, 32'd10);
    chk("shrink_before", p_dat[1], 0);
    tick();
    chk("shrink_after", p_dat[1], 1);
    pins[1] = 1'b0;
    repeat (15) tick();

    // Reset mid-count with enables set
    wr(32'h4, 32'hFFFF);
    wr(32'h8, 32'hFFFF);
    pins[2] = 1'b1;
    repeat (6) tick();
    rstn = 1'b0;
    tick();
    chk("rst_mid_filt", p_dat, 0);
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    chk("rst_requal", p_dat[2], 1);
    rd_expect("rst_no_event", 32'hC, 32'h0);
    chk("rst_no_irq", irq, 0);
    pins = '0;
    repeat (4) tick();

    // Randomized traffic against the reference model
    wr(32'h0, 32'($urandom_range(0, 3)));
    wr(32'h4, $urandom);
    wr(32'h8, $urandom);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, 15)] ^= 1'b1;
      op = $urandom_range(0, 31);
      addr = 4 * $urandom_range(0, 6);
      wdata = $urandom;
      if (op < 6) ren = 1'b1;
      else if (op == 6) begin addr = 32'hC; wen = 1'b1; end
      else if (op == 7) begin addr = 32'h0; wdata = 32'($urandom_range(0, 5)); wen = 1'b1; end
      else if (op == 8) begin addr = 32'h4 * $urandom_range(1, 2); wen = 1'b1; end
      tick();
      wen = 1'b0; ren = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
